// File: rtl/piezo_seq.sv
// Table-driven piezo note sequencer: battery-low loop, fanfare and chirp tunes
// with clock-derived pitch, selectable duty, inter-note gaps and preemption.
module piezo_seq #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter bit          FAST_SIM  = 1'b1,
  parameter int unsigned DUR_SHIFT = 22,
  parameter int unsigned GAP_CNT   = 1 << 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       batt_low,
  input  logic       fanfare,
  input  logic       chirp,
  input  logic [1:0] vol,
  output logic       piezo,
  output logic       piezo_n,
  output logic       busy,
  output logic       done
);

  localparam int unsigned H_G6  = CLK_FREQ / (2 * 1568);
  localparam int unsigned H_C7  = CLK_FREQ / (2 * 2093);
  localparam int unsigned H_E7  = CLK_FREQ / (2 * 2637);
  localparam int unsigned H_G7  = CLK_FREQ / (2 * 3136);
  // G6 is the lowest note, so its full period bounds the pitch counter
  localparam int unsigned PER_W = $clog2(2 * H_G6);
  // three extra bits so a 4-unit note fits without wrapping
  localparam int unsigned DUR_W = DUR_SHIFT + 3;
  // one more bit so dur + step never overflows during the compare
  localparam int unsigned CMP_W = DUR_W + 1;
  localparam logic [CMP_W-1:0] STEP    = FAST_SIM ? CMP_W'(16) : CMP_W'(1);
  localparam logic [CMP_W-1:0] GAP_LIM = CMP_W'(GAP_CNT);

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;
  typedef enum logic [1:0] {T_B, T_F, T_C} tune_t;
  typedef enum logic [1:0] {N_G6, N_C7, N_E7, N_G7} note_t;
  typedef struct packed {
    note_t      note;
    logic [2:0] units;
    logic       last;
  } entry_t;

  function automatic entry_t rom(input tune_t t, input logic [2:0] i);
    entry_t e;
    e = '{N_G7, 3'd1, 1'b1};
    case (t)
      T_B: case (i)
        3'd0:    e = '{N_G6, 3'd2, 1'b0};
        3'd1:    e = '{N_C7, 3'd2, 1'b0};
        default: e = '{N_E7, 3'd2, 1'b1};
      endcase
      T_F: case (i)
        3'd0:    e = '{N_G6, 3'd2, 1'b0};
        3'd1:    e = '{N_C7, 3'd2, 1'b0};
        3'd2:    e = '{N_E7, 3'd2, 1'b0};
        3'd3:    e = '{N_G7, 3'd2, 1'b0};
        3'd4:    e = '{N_G7, 3'd1, 1'b0};
        3'd5:    e = '{N_E7, 3'd1, 1'b0};
        default: e = '{N_G7, 3'd4, 1'b1};
      endcase
      default: e = '{N_G7, 3'd1, 1'b1};
    endcase
    return e;
  endfunction

  function automatic logic [PER_W-1:0] half_of(input note_t n);
    case (n)
      N_G6:    return PER_W'(H_G6);
      N_C7:    return PER_W'(H_C7);
      N_E7:    return PER_W'(H_E7);
      default: return PER_W'(H_G7);
    endcase
  endfunction

  state_t           state_q, state_d;
  tune_t            tune_q, tune_d, ld_tune;
  logic [2:0]       idx_q, idx_d, ld_idx;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] half_q, half_d;
  logic [PER_W-1:0] high_q, high_d;
  logic [2:0]       units_q, units_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             load;
  entry_t           ld_ent;
  logic [CMP_W-1:0] dur_nx, note_lim;
  logic [PER_W:0]   per_top;

  assign dur_nx   = {1'b0, dur_q} + STEP;
  assign note_lim = CMP_W'(units_q) << DUR_SHIFT;
  assign per_top  = {half_q, 1'b0} - {{PER_W{1'b0}}, 1'b1};

  // next-state: tune progression, preemption and per-note parameter load
  always_comb begin
    state_d = state_q;
    tune_d  = tune_q;
    idx_d   = idx_q;
    dur_d   = dur_q;
    per_d   = per_q;
    half_d  = half_q;
    high_d  = high_q;
    units_d = units_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    ld_tune = tune_q;
    ld_idx  = idx_q;
    ld_ent  = '{N_G7, 3'd1, 1'b1};

    case (state_q)
      S_IDLE: begin
        dur_d = '0;
        per_d = '0;
        if (batt_low)     begin load = 1'b1; ld_tune = T_B; ld_idx = 3'd0; end
        else if (fanfare) begin load = 1'b1; ld_tune = T_F; ld_idx = 3'd0; end
        else if (chirp)   begin load = 1'b1; ld_tune = T_C; ld_idx = 3'd0; end
      end
      S_NOTE: begin
        per_d = ({1'b0, per_q} == per_top) ? '0 : per_q + 1'b1;
        dur_d = dur_nx[DUR_W-1:0];
        if (dur_nx >= note_lim) begin
          if (last_q) begin
            // final note never has a trailing gap
            if (tune_q == T_B && batt_low) begin
              load = 1'b1; ld_tune = T_B; ld_idx = 3'd0;
            end else begin
              state_d = S_IDLE;
              dur_d   = '0;
              per_d   = '0;
              done_d  = 1'b1;
            end
          end else if (GAP_CNT == 0) begin
            load = 1'b1; ld_idx = idx_q + 3'd1;
          end else begin
            state_d = S_GAP;
            dur_d   = '0;
            per_d   = '0;
          end
        end
      end
      S_GAP: begin
        per_d = '0;
        dur_d = dur_nx[DUR_W-1:0];
        if (dur_nx >= GAP_LIM) begin
          load = 1'b1; ld_idx = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // higher-priority requests abort the running tune without a done pulse
    if (state_q != S_IDLE) begin
      if (batt_low && tune_q != T_B) begin
        load = 1'b1; ld_tune = T_B; ld_idx = 3'd0; done_d = 1'b0;
      end else if (fanfare && tune_q == T_C) begin
        load = 1'b1; ld_tune = T_F; ld_idx = 3'd0; done_d = 1'b0;
      end
    end

    if (load) begin
      ld_ent  = rom(ld_tune, ld_idx);
      state_d = S_NOTE;
      tune_d  = ld_tune;
      idx_d   = ld_idx;
      dur_d   = '0;
      per_d   = '0;
      half_d  = half_of(ld_ent.note);
      units_d = ld_ent.units;
      last_d  = ld_ent.last;
      // volume is captured once per note
      case (vol)
        2'd3:    high_d = half_of(ld_ent.note);
        2'd2:    high_d = half_of(ld_ent.note) >> 1;
        2'd1:    high_d = half_of(ld_ent.note) >> 2;
        default: high_d = '0;
      endcase
    end
  end

  // state and counter registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tune_q  <= T_B;
      idx_q   <= '0;
      dur_q   <= '0;
      per_q   <= '0;
      half_q  <= '0;
      high_q  <= '0;
      units_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tune_q  <= tune_d;
      idx_q   <= idx_d;
      dur_q   <= dur_d;
      per_q   <= per_d;
      half_q  <= half_d;
      high_q  <= high_d;
      units_q <= units_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign piezo   = (state_q == S_NOTE) && (per_q < high_q);
  assign piezo_n = ~piezo;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule
